// File: rtl/bsg_demux_buffered_width_p64_els_p2_pkg.sv
// Shared constants and helpers for the buffered demux: sel width and per-channel buffer depth.
package bsg_demux_pkg;

    localparam int bsg_demux_buf_els_gp = 2;

    // clog2 that never returns 0, so a 1-channel build still gets a 1-bit select
    function automatic int bsg_demux_sel_width(input int els);
        return (els <= 1) ? 1 : $clog2(els);
    endfunction

endpackage

// File: rtl/bsg_demux_buffered_width_p64_els_p2_if.sv
// Producer/consumer bundle of the buffered demux; master drives stimulus, slave is the demux.
interface bsg_demux_buffered_width_p64_els_p2_if
    import bsg_demux_pkg::*;
#(
    parameter int width_p = 64,
    parameter int els_p   = 2
);

    localparam int sel_width_lp = bsg_demux_sel_width(els_p);

    logic                      v_i;
    logic [width_p-1:0]        data_i;
    logic [sel_width_lp-1:0]   sel_i;
    logic                      ready_o;
    logic [els_p-1:0]          v_o;
    logic [els_p*width_p-1:0]  data_o;
    logic [els_p-1:0]          yumi_i;
    logic                      err_o;

    modport master (
        output v_i, data_i, sel_i, yumi_i,
        input  ready_o, v_o, data_o, err_o
    );

    modport slave (
        input  v_i, data_i, sel_i, yumi_i,
        output ready_o, v_o, data_o, err_o
    );

endinterface

// File: rtl/bsg_demux_buffered_width_p64_els_p2_two_fifo.sv
// Two-entry ready/valid FIFO with pointer-based head/tail and registered full/empty flags.
module bsg_demux_two_fifo
    import bsg_demux_pkg::*;
#(
    parameter int width_p = 64
)
(
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               enq_i,
    input  logic [width_p-1:0] data_i,
    input  logic               deq_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    output logic               full_o
);

    localparam int ptr_w_lp = $clog2(bsg_demux_buf_els_gp);

    logic [width_p-1:0]  mem_p0 [bsg_demux_buf_els_gp];
    logic [ptr_w_lp-1:0] wptr_r, rptr_r;
    logic                full_r, empty_r;
    logic                do_enq, do_deq;

    // Caller guarantees no enqueue while full; dequeue is masked to a valid head
    assign do_enq = enq_i & ~full_r;
    assign do_deq = deq_i & ~empty_r;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            full_r  <= 1'b0;
            empty_r <= 1'b1;
        end else begin
            if (do_enq) wptr_r <= wptr_r + 1'b1;
            if (do_deq) rptr_r <= rptr_r + 1'b1;
            if (do_enq && !do_deq) begin
                empty_r <= 1'b0;
                full_r  <= ((wptr_r + 1'b1) == rptr_r);
            end else if (do_deq && !do_enq) begin
                full_r  <= 1'b0;
                empty_r <= ((rptr_r + 1'b1) == wptr_r);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_enq) mem_p0[wptr_r] <= data_i;
    end

    // Storage is not reset, so an empty buffer presents zero instead of stale/unknown data
    assign v_o    = ~empty_r;
    assign data_o = empty_r ? '0 : mem_p0[rptr_r];
    assign full_o = full_r;

endmodule

// File: rtl/bsg_demux_buffered_width_p64_els_p2.sv
// Buffered 1:N demux: steers a ready/valid word stream to one of els_p independently buffered channels.
module bsg_demux_buffered_width_p64_els_p2
    import bsg_demux_pkg::*;
#(
    parameter int width_p     = 64,
    parameter int els_p       = 2,
    parameter bit assert_en_p = 1'b1
)
(
    input  logic clk_i,
    input  logic reset_n_i,
    bsg_demux_buffered_width_p64_els_p2_if.slave io
);

    localparam int sel_width_lp = bsg_demux_sel_width(els_p);
    localparam int sel_span_lp  = 1 << sel_width_lp;

    logic [els_p-1:0]       full, vld_p1, enq, deq, illegal_yumi;
    logic [sel_span_lp-1:0] full_span;
    logic                   sel_in_range;
    logic                   ready;
    logic                   err_r;

    // Unused select codes look permanently full so ready_o stays low for them
    always_comb begin
        full_span              = '1;
        full_span[els_p-1:0]   = full;
    end

    assign sel_in_range = (32'(io.sel_i) < els_p);
    assign ready        = reset_n_i & sel_in_range & ~full_span[io.sel_i];
    assign io.ready_o   = ready;

    assign io.v_o          = vld_p1 & {els_p{reset_n_i}};
    assign deq             = io.yumi_i & io.v_o;
    assign illegal_yumi    = io.yumi_i & ~io.v_o;

    for (genvar k = 0; k < els_p; k++) begin : g_ch
        assign enq[k] = io.v_i & ready & (io.sel_i == sel_width_lp'(k));

        bsg_demux_two_fifo #(.width_p(width_p)) u_fifo (
            .clk_i     (clk_i),
            .reset_n_i (reset_n_i),
            .enq_i     (enq[k]),
            .data_i    (io.data_i),
            .deq_i     (deq[k]),
            .v_o       (vld_p1[k]),
            .data_o    (io.data_o[k*width_p +: width_p]),
            .full_o    (full[k])
        );
    end

    // Sticky error: an unroutable word was offered or a consumer popped an empty channel
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            err_r <= 1'b0;
        end else if ((io.v_i & ~sel_in_range) | (|illegal_yumi)) begin
            err_r <= 1'b1;
        end
    end

    assign io.err_o = err_r;

    always_ff @(posedge clk_i) begin
        if (assert_en_p && reset_n_i) begin
            assert (illegal_yumi == '0);
        end
    end

endmodule

// File: tb/tb_bsg_demux_buffered_width_p64_els_p2.sv
// Randomised and directed bench for the buffered demux, checked against a queue-based channel model.
module tb_bsg_demux_buffered_width_p64_els_p2;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    bsg_demux_buffered_width_p64_els_p2_if #(.width_p(64), .els_p(2)) dif ();
    bsg_demux_buffered_width_p64_els_p2_if #(.width_p(64), .els_p(3)) dif3 ();

    bsg_demux_buffered_width_p64_els_p2 #(.width_p(64), .els_p(2), .assert_en_p(1'b0)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .io(dif.slave));

    bsg_demux_buffered_width_p64_els_p2 #(.width_p(64), .els_p(3), .assert_en_p(1'b0)) dut3 (
        .clk_i(clk), .reset_n_i(reset_n), .io(dif3.slave));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each channel is a queue of words currently held by the demux
    logic [63:0] q0[$];
    logic [63:0] q1[$];
    bit          err_m = 1'b0;

    always @(negedge clk) begin
        logic       exp_ready;
        logic [1:0] exp_v;
        int         occ;
        occ       = dif.sel_i ? q1.size() : q0.size();
        exp_ready = reset_n && (occ < 2);
        exp_v     = reset_n ? {q1.size() != 0, q0.size() != 0} : 2'b00;
        check("mon_ready", 64'(dif.ready_o), 64'(exp_ready));
        check("mon_v_o", 64'(dif.v_o), 64'(exp_v));
        check("mon_err", 64'(dif.err_o), 64'(err_m));
        if (exp_v[0] && dif.yumi_i[0]) check("mon_data0", dif.data_o[63:0], q0[0]);
        if (exp_v[1] && dif.yumi_i[1]) check("mon_data1", dif.data_o[127:64], q1[0]);
        if (!reset_n) begin
            q0.delete();
            q1.delete();
            err_m = 1'b0;
        end else begin
            if ((dif.yumi_i & ~exp_v) != 2'b00) err_m = 1'b1;
            if (dif.yumi_i[0] && exp_v[0]) void'(q0.pop_front());
            if (dif.yumi_i[1] && exp_v[1]) void'(q1.pop_front());
            if (dif.v_i && exp_ready) begin
                if (dif.sel_i) q1.push_back(dif.data_i);
                else           q0.push_back(dif.data_i);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic s, input logic [63:0] d);
        bit done = 1'b0;
        dif.v_i = 1'b1; dif.sel_i = s; dif.data_i = d;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (dif.ready_o) done = 1'b1;
            step();
        end
        dif.v_i = 1'b0;
        if (!done) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        dif.v_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            dif.yumi_i = dif.v_o;
            step();
        end
        dif.yumi_i = 2'b00;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        dif.v_i = 1'b1; dif.sel_i = 1'b0; dif.data_i = '0; dif.yumi_i = 2'b11;
        dif3.v_i = 1'b0; dif3.sel_i = '0; dif3.data_i = '0; dif3.yumi_i = '0;

        // Reset hold with live inputs
        repeat (3) step();
        @(negedge clk);
        check("rst_ready", 64'(dif.ready_o), 64'd0);
        check("rst_v_o", 64'(dif.v_o), 64'd0);
        check("rst_err", 64'(dif.err_o), 64'd0);
        step();
        reset_n = 1'b1; dif.yumi_i = 2'b00;
        dif.v_i = 1'b1; dif.sel_i = 1'b0; dif.data_i = 64'hA5;
        @(negedge clk);
        check("first_ready", 64'(dif.ready_o), 64'd1);
        step();
        dif.v_i = 1'b0;
        @(negedge clk);
        check("first_v_o", 64'(dif.v_o), 64'd1);
        check("first_data", dif.data_o[63:0], 64'hA5);
        step();

        // Backpressure on ch1 while ch0 still accepts
        send(1'b1, 64'd1);
        send(1'b1, 64'd2);
        dif.v_i = 1'b1; dif.sel_i = 1'b1; dif.data_i = 64'd3;
        @(negedge clk);
        check("bp_ready_full", 64'(dif.ready_o), 64'd0);
        step();
        dif.sel_i = 1'b0; dif.data_i = 64'd7;
        @(negedge clk);
        check("bp_ready_ch0", 64'(dif.ready_o), 64'd1);
        step();
        dif.v_i = 1'b0; dif.yumi_i = 2'b10;
        @(negedge clk);
        check("bp_pop1", dif.data_o[127:64], 64'd1);
        step();
        @(negedge clk);
        check("bp_pop2", dif.data_o[127:64], 64'd2);
        step();
        dif.yumi_i = 2'b00;
        send(1'b1, 64'd3);
        @(negedge clk);
        check("bp_word3", dif.data_o[127:64], 64'd3);
        step();

        // Reset with both buffers full drops everything
        send(1'b1, 64'd4);
        @(negedge clk);
        check("full_v_o", 64'(dif.v_o), 64'd3);
        step();
        pulse_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_v_o", 64'(dif.v_o), 64'd0);
            check("midrst_err", 64'(dif.err_o), 64'd0);
            step();
        end

        // Streaming into ch0 with consumer always taking
        for (int i = 0; i < 16; i++) begin
            dif.v_i = 1'b1; dif.sel_i = 1'b0; dif.data_i = 64'h10 + 64'(i);
            dif.yumi_i = {1'b0, dif.v_o[0]};
            @(negedge clk);
            check("stream_ready", 64'(dif.ready_o), 64'd1);
            if (i > 0) check("stream_data", dif.data_o[63:0], 64'h10 + 64'(i - 1));
            step();
        end
        drain();

        // Simultaneous enqueue and dequeue at occupancy 1
        send(1'b0, 64'hAA);
        dif.v_i = 1'b1; dif.sel_i = 1'b0; dif.data_i = 64'hBB; dif.yumi_i = 2'b01;
        @(negedge clk);
        check("simul_ready", 64'(dif.ready_o), 64'd1);
        step();
        dif.v_i = 1'b0; dif.yumi_i = 2'b00;
        @(negedge clk);
        check("simul_v_o", 64'(dif.v_o), 64'd1);
        check("simul_data", dif.data_o[63:0], 64'hBB);
        step();
        drain();

        // Illegal yumi on empty ch1 sets a sticky error
        dif.yumi_i = 2'b10;
        step();
        dif.yumi_i = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("err_sticky", 64'(dif.err_o), 64'd1);
            step();
        end

        // Three-channel build: select 3 is unroutable
        dif3.v_i = 1'b1; dif3.sel_i = 2'd3; dif3.data_i = 64'h55;
        @(negedge clk);
        check("e3_ready_oor", 64'(dif3.ready_o), 64'd0);
        step();
        dif3.sel_i = 2'd2; dif3.data_i = 64'h66;
        @(negedge clk);
        check("e3_err", 64'(dif3.err_o), 64'd1);
        check("e3_ready_ch2", 64'(dif3.ready_o), 64'd1);
        step();
        dif3.v_i = 1'b0;
        @(negedge clk);
        check("e3_v_o", 64'(dif3.v_o), 64'd4);
        check("e3_data", dif3.data_o[191:128], 64'h66);
        step();

        pulse_reset();
        @(negedge clk);
        check("err_cleared", 64'(dif.err_o), 64'd0);
        step();

        // Random traffic with legal consumers
        for (int i = 0; i < 600; i++) begin
            dif.v_i    = 1'($urandom);
            dif.sel_i  = 1'($urandom);
            dif.data_i = {$urandom, $urandom};
            dif.yumi_i = 2'($urandom) & dif.v_o;
            step();
        end
        drain();
        @(negedge clk);
        check("final_v_o", 64'(dif.v_o), 64'd0);
        check("final_err", 64'(dif.err_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
